// File: rtl/btn_pkg.sv
`default_nettype none
// btn_pkg: shared state encoding and timer sizing for the button/LED pulse blocks.
// Revision: 1.0
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Wide enough to hold the larger of the two phase lengths.
  function automatic int tmr_width(input int on_cycles, input int off_cycles);
    int longest;
    longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// sat_counter: up/down counter that saturates at MAX and flags a dropped increment.
// Revision: 1.0
module sat_counter #(
  parameter int MAX   = 3,
  parameter int WIDTH = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      // Simultaneous inc and dec cancel, so a full counter never overflows on a consume cycle.
      if (inc && !dec) begin
        if (count == MAX_VAL) begin
          ovf <= 1'b1;
        end else begin
          count <= count + ONE;
        end
      end else if (dec && !inc && (count != '0)) begin
        count <= count - ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/btn_led_pulser.sv
`default_nettype none
// btn_led_pulser: stretches single-cycle events into fixed LED pulses with a dark gap,
// queueing events that arrive mid-pulse. Revision: 1.0
module btn_led_pulser
  import btn_pkg::*;
#(
  parameter int ON_CYCLES  = 20,
  parameter int OFF_CYCLES = 10,
  parameter int MAX_PEND   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic evt,
  output logic led,
  output logic busy,
  output logic ovf
);

  localparam int TMR_W  = tmr_width(ON_CYCLES, OFF_CYCLES);
  localparam int PEND_W = $clog2(MAX_PEND + 1);

  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  state_t            state;
  state_t            state_next;
  logic [TMR_W-1:0]  tmr;
  logic [TMR_W-1:0]  tmr_next;
  logic [PEND_W-1:0] pend;
  logic              pend_inc;
  logic              pend_dec;

  always_comb begin
    state_next = state;
    tmr_next   = tmr;
    pend_inc   = 1'b0;
    pend_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (evt) begin
          state_next = ON;
          tmr_next   = ON_LOAD;
        end
      end
      ON: begin
        pend_inc = evt;
        if (tmr == '0) begin
          state_next = GAP;
          tmr_next   = OFF_LOAD;
        end else begin
          tmr_next = tmr - TMR_ONE;
        end
      end
      GAP: begin
        pend_inc = evt;
        if (tmr == '0) begin
          // A live event here is consumed directly: inc and dec cancel in the counter.
          if ((pend != '0) || evt) begin
            state_next = ON;
            tmr_next   = ON_LOAD;
            pend_dec   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          tmr_next = tmr - TMR_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        tmr_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tmr   <= '0;
      led   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      tmr   <= tmr_next;
      led   <= (state_next == ON);
      busy  <= (state_next != IDLE);
    end
  end

  sat_counter #(
    .MAX   (MAX_PEND),
    .WIDTH (PEND_W)
  ) u_pend (
    .clk   (clk),
    .rst   (rst),
    .inc   (pend_inc),
    .dec   (pend_dec),
    .count (pend),
    .ovf   (ovf)
  );

endmodule
`default_nettype wire

// File: tb/tb_btn_led_pulser.sv
`default_nettype none
// tb_btn_led_pulser: directed scenarios; expectations queued per cycle, checked by a monitor.
// Revision: 1.0
module tb_btn_led_pulser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic evt = 1'b0;
  logic led;
  logic busy;
  logic ovf;

  btn_led_pulser #(
    .ON_CYCLES  (20),
    .OFF_CYCLES (10),
    .MAX_PEND   (3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .evt  (evt),
    .led  (led),
    .busy (busy),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   lbl;
    logic led;
    logic busy;
    logic ovf;
    int   pend;
  } exp_t;

  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string cur_name = "init";

  function automatic logic [127:0] win(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic push_exp(input int lbl, input logic l, input logic b, input logic o, input int p);
    exp_t e;
    e.lbl  = lbl;
    e.led  = l;
    e.busy = b;
    e.ovf  = o;
    e.pend = p;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if ({led, busy, ovf} !== {e.led, e.busy, e.ovf}) begin
          n_fail++;
          $display("FAIL %s cycle %0d: led/busy/ovf = %b%b%b, expected %b%b%b",
                   cur_name, e.lbl, led, busy, ovf, e.led, e.busy, e.ovf);
        end
        if (e.pend >= 0) begin
          n_tests++;
          if (dut.pend !== 2'(e.pend)) begin
            n_fail++;
            $display("FAIL %s cycle %0d pend: got %0d, expected %0d",
                     cur_name, e.lbl, dut.pend, e.pend);
          end
        end
      end
    end
  end

  // Three reset cycles with EVT toggling; every output must stay low.
  task automatic reset_prelude();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b1;
      evt = (i % 2 == 0);
      push_exp(i - 3, 1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  // Label c+1 is the output seen just after the edge that sampled the stimulus of cycle c.
  task automatic run(input string name, input int ncyc,
                     input logic [127:0] evts, input logic [127:0] rsts,
                     input logic [127:0] led_m, input logic [127:0] busy_m,
                     input logic [127:0] ovf_m,
                     input int pc0, input int pv0, input int pc1, input int pv1);
    int p;
    cur_name = name;
    reset_prelude();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      evt = evts[c];
      rst = rsts[c];
      p = (c + 1 == pc0) ? pv0 : ((c + 1 == pc1) ? pv1 : -1);
      push_exp(c + 1, led_m[c + 1], busy_m[c + 1], ovf_m[c + 1], p);
    end
    @(negedge clk);
    evt = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 4 && sb.size() != 0; k++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s drain: %0d expectations unchecked, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin : stimulus
    run("reset", 30, '0, '0, '0, '0, '0, 5, 0, 25, 0);

    run("single", 40, win(2, 2), '0,
        win(3, 22), win(3, 32), '0, -1, 0, -1, 0);

    run("queued", 70, win(2, 2) | win(7, 7), '0,
        win(3, 22) | win(33, 52), win(3, 62), '0, 20, 1, 33, 0);

    run("overflow", 126, win(2, 2) | win(5, 9), '0,
        win(3, 22) | win(33, 52) | win(63, 82) | win(93, 112),
        win(3, 122), win(9, 10), 10, 3, 93, 0);

    run("final_gap_pend0", 70, win(2, 2) | win(32, 32), '0,
        win(3, 22) | win(33, 52), win(3, 62), '0, 33, 0, 45, 0);

    run("final_gap_pend1", 100, win(2, 2) | win(10, 10) | win(32, 32), '0,
        win(3, 22) | win(33, 52) | win(63, 82), win(3, 92), '0, 33, 1, 63, 0);

    run("reset_mid", 70, win(2, 2) | win(4, 4) | win(6, 6), win(10, 12),
        win(3, 10), win(3, 10), '0, 9, 2, 11, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
